fd_multiciclo: RTL and testbench
================================

Name: fd_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle processor datapath.
- Contains the register bank, an ALU/address unit, a synchronous data memory and the write-back selection, sequenced by an internal FSM.
- Accepts one command at a time through a valid/ready handshake and signals completion with a one-cycle done pulse.
- Adds status flags, illegal-op detection, a hardwired-zero register and a debug read port.

Parameters:
DATA_W, 64, datapath and register width in bits
REG_ADDR_W, 5, register address width; bank holds 2**REG_ADDR_W registers
MEM_ADDR_W, 5, memory address width; memory holds 2**MEM_ADDR_W words of DATA_W bits

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
OP  in  3  opcode: 0 ADD, 1 SUB, 2 ADDI, 3 SUBI, 4 LOAD, 5 STORE, 6-7 illegal
Ra  in  REG_ADDR_W  source register A
Rb  in  REG_ADDR_W  source register B / memory base register
Rw  in  REG_ADDR_W  destination register
OFFSET  in  DATA_W  immediate or memory offset
done  out  1  one-cycle pulse: command completed
result  out  DATA_W  value of the last completed command
flags  out  6  {lt, eq, ovf, carry, neg, zero}
err_op  out  1  last accepted command was illegal
busy  out  1  FSM not in IDLE
dbg_addr  in  REG_ADDR_W  debug register address
dbg_data  out  DATA_W  combinational read of reg[dbg_addr]

Behaviour:
Reset (rst_n low, asynchronous):
- FSM to IDLE; all registers in the bank to 0.
- done=0, result=0, flags=0, err_op=0.
- Memory contents are not reset.
- Any memory or register write in flight is suppressed.

Register bank:
- Combinational reads; writes on the rising edge.
- Register 0 always reads 0; writes to it are discarded.

Handshake:
- cmd_ready=1 only in IDLE.
- A command is accepted on the edge where cmd_valid & cmd_ready.
- On that edge the block captures OP, Rw and OFFSET, plus A=reg[Ra] and B=reg[Rb].
- OP, Ra, Rb, Rw and OFFSET may change freely after acceptance.

FSM states:
- IDLE: wait for an accepted command; go to EXEC.
- EXEC:
  - ADD: A+B; SUB: A-B.
  - ADDI: A+OFFSET; SUBI: A-OFFSET.
  - LOAD/STORE: address = B+OFFSET.
  - At the edge: latch ALU_OUT and update flags.
  - Next state: MEM for LOAD/STORE, WB otherwise.
  - Illegal OP: ALU_OUT=0, flags unchanged, err_op=1, go to WB.
- MEM:
  - Memory address = ALU_OUT[MEM_ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo depth.
  - STORE: mem[addr] <= A at the edge.
  - LOAD: synchronous read; data is registered at the edge.
  - Go to WB.
- WB:
  - The write-back value is the load data for LOAD and ALU_OUT otherwise.
  - The register write occurs at the edge only for OP 0-4 with Rw != 0.
  - result <= write-back value; STORE returns the address and illegal ops return 0.
  - done <= 1 for one cycle; go to IDLE.
- err_op is updated at every EXEC: 1 for an illegal OP, 0 otherwise.

Latency:
- The done pulse appears 3 edges after the accept edge for ALU or illegal ops.
- It appears 4 edges after the accept edge for LOAD/STORE.
- done coincides with cmd_ready=1, so back-to-back commands are possible.
- The register written in WB is visible to a command accepted in the done cycle; no hazard logic is needed.

Flags (width DATA_W):
- zero: result == 0.
- neg: result MSB.
- carry: carry-out for add; no-borrow for subtract.
- ovf: signed overflow.
- eq: first operand == second operand.
- lt: signed first operand < second operand.
- Flags hold their value until the next legal EXEC.

Other outputs:
- busy = !cmd_ready.
- dbg_data is always valid and reflects writes after the WB edge.

Test Plan:
- Reset, then ADDI r1=r0+5, ADDI r2=r0+7, ADD r3=r1+r2 -> done 3 edges after each accept; result=12; dbg r3=12; flags zero=0 neg=0.
- SUBI r4=r0-1 -> result=64'hFFFF_FFFF_FFFF_FFFF, neg=1, carry=0, lt=1. ADDI r5=r0+64'h7FFF_FFFF_FFFF_FFFF, then ADDI r5=r5+1 -> ovf=1, neg=1.
- r1=5 and OFFSET=35: STORE r3 at mem[r1+35] -> address 40 wraps to 8; result=40. LOAD r6=mem[r0+8] -> done 4 edges after accept; r6=12.
- OP=6 -> err_op=1, no register or memory change, flags unchanged, done after 3 edges. ADDI with Rw=0 and OFFSET=9 -> r0 still reads 0.
- Hold cmd_valid high for 4 ADDI r1=r1+1 commands -> each accepted in its done cycle; r1 increments by 1 per command with no lost updates.
- Assert rst_n low during MEM of a STORE -> memory word unchanged, no done pulse, all registers 0, cmd_ready=1 on release.

Source files
------------

// File: rtl/fd_multiciclo.sv
// Multi-cycle datapath: register bank, ALU/address unit, synchronous data memory
// and write-back selection, sequenced by a four-state FSM behind a valid/ready handshake.
module fd_multiciclo #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            OP,
    input  logic [REG_ADDR_W-1:0] Ra,
    input  logic [REG_ADDR_W-1:0] Rb,
    input  logic [REG_ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0]     OFFSET,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic [5:0]            flags,
    output logic                  err_op,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int NMEM = 2 ** MEM_ADDR_W;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_SUBI  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [2:0]              op_r;
    logic [REG_ADDR_W-1:0]   rw_r;
    logic [DATA_W-1:0]       off_r, a_r, b_r;
    logic [DATA_W-1:0]       alu_r, ld_data_r, result_r;
    logic [5:0]              flags_r;
    logic                    err_op_r, done_r;
    logic [DATA_W-1:0]       regs_r [NREG];
    logic [DATA_W-1:0]       mem_r  [NMEM];

    logic                    accept_s, op_legal_s, is_mem_op_s, reg_we_s;
    logic [DATA_W-1:0]       rd_a_s, rd_b_s, wb_val_s;
    logic [DATA_W-1:0]       opx_s, opy_s, opy_eff_s, alu_res_s;
    logic                    sub_s;
    logic [DATA_W:0]         sum_s;
    logic [5:0]              flags_calc_s;
    logic [MEM_ADDR_W-1:0]   mem_addr_s;

    // Register 0 is hardwired to zero on every read port.
    assign rd_a_s   = (Ra == {REG_ADDR_W{1'b0}})       ? {DATA_W{1'b0}} : regs_r[Ra];
    assign rd_b_s   = (Rb == {REG_ADDR_W{1'b0}})       ? {DATA_W{1'b0}} : regs_r[Rb];
    assign dbg_data = (dbg_addr == {REG_ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[dbg_addr];

    assign accept_s    = cmd_valid && (state_r == ST_IDLE);
    assign op_legal_s  = (op_r <= OP_STORE);
    assign is_mem_op_s = (op_r == OP_LOAD) || (op_r == OP_STORE);
    assign reg_we_s    = (state_r == ST_WB) && (op_r <= OP_LOAD) && (rw_r != {REG_ADDR_W{1'b0}});
    assign mem_addr_s  = alu_r[MEM_ADDR_W-1:0];

    // Operand selection and shared adder; subtraction is A + ~B + 1 so carry means no-borrow.
    always_comb begin
        opx_s = a_r;
        opy_s = b_r;
        sub_s = 1'b0;
        case (op_r)
            OP_ADD:   begin opx_s = a_r; opy_s = b_r;   sub_s = 1'b0; end
            OP_SUB:   begin opx_s = a_r; opy_s = b_r;   sub_s = 1'b1; end
            OP_ADDI:  begin opx_s = a_r; opy_s = off_r; sub_s = 1'b0; end
            OP_SUBI:  begin opx_s = a_r; opy_s = off_r; sub_s = 1'b1; end
            OP_LOAD,
            OP_STORE: begin opx_s = b_r; opy_s = off_r; sub_s = 1'b0; end
            default:  begin opx_s = a_r; opy_s = b_r;   sub_s = 1'b0; end
        endcase
        opy_eff_s    = sub_s ? ~opy_s : opy_s;
        sum_s        = {1'b0, opx_s} + {1'b0, opy_eff_s} + {{DATA_W{1'b0}}, sub_s};
        alu_res_s    = sum_s[DATA_W-1:0];
        flags_calc_s = {
            ($signed(opx_s) < $signed(opy_s)),
            (opx_s == opy_s),
            ((opx_s[DATA_W-1] == opy_eff_s[DATA_W-1]) && (alu_res_s[DATA_W-1] != opx_s[DATA_W-1])),
            sum_s[DATA_W],
            alu_res_s[DATA_W-1],
            (alu_res_s == {DATA_W{1'b0}})
        };
    end

    // Write-back source selection.
    always_comb begin
        if (op_r == OP_LOAD) begin
            wb_val_s = ld_data_r;
        end else begin
            wb_val_s = alu_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (is_mem_op_s) state_nxt_s = ST_MEM;
                else             state_nxt_s = ST_WB;
            end
            ST_MEM:  state_nxt_s = ST_WB;
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready = (state_r == ST_IDLE);
        busy      = (state_r != ST_IDLE);
    end

    // Command capture on the accept edge; inputs are free to change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 3'd0;
            rw_r  <= {REG_ADDR_W{1'b0}};
            off_r <= {DATA_W{1'b0}};
            a_r   <= {DATA_W{1'b0}};
            b_r   <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            op_r  <= OP;
            rw_r  <= Rw;
            off_r <= OFFSET;
            a_r   <= rd_a_s;
            b_r   <= rd_b_s;
        end else begin
            op_r  <= op_r;
            rw_r  <= rw_r;
            off_r <= off_r;
            a_r   <= a_r;
            b_r   <= b_r;
        end
    end

    // EXEC latches the ALU result and flags; illegal ops zero the result and keep flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_r    <= {DATA_W{1'b0}};
            flags_r  <= 6'd0;
            err_op_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            err_op_r <= !op_legal_s;
            if (op_legal_s) begin
                alu_r   <= alu_res_s;
                flags_r <= flags_calc_s;
            end else begin
                alu_r   <= {DATA_W{1'b0}};
                flags_r <= flags_r;
            end
        end else begin
            alu_r    <= alu_r;
            flags_r  <= flags_r;
            err_op_r <= err_op_r;
        end
    end

    // Load data register and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_data_r <= {DATA_W{1'b0}};
            result_r  <= {DATA_W{1'b0}};
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == ST_WB);
            if ((state_r == ST_MEM) && (op_r == OP_LOAD)) ld_data_r <= mem_r[mem_addr_s];
            else                                          ld_data_r <= ld_data_r;
            if (state_r == ST_WB) result_r <= wb_val_s;
            else                  result_r <= result_r;
        end
    end

    // Register bank: cleared by reset, written in WB, register 0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_r[i] <= {DATA_W{1'b0}};
        end else if (reg_we_s) begin
            regs_r[rw_r] <= wb_val_s;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Data memory is not reset; reset forces IDLE, which blocks an in-flight store.
    always_ff @(posedge clk) begin
        if ((state_r == ST_MEM) && (op_r == OP_STORE)) begin
            mem_r[mem_addr_s] <= a_r;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign done   = done_r;
    assign result = result_r;
    assign flags  = flags_r;
    assign err_op = err_op_r;

endmodule

// File: tb/tb_fd_multiciclo.sv
// Directed bench for fd_multiciclo: hand-computed vectors checked with immediate assertions.
module tb_fd_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  OP;
    logic [4:0]  Ra, Rb, Rw;
    logic [63:0] OFFSET;
    logic        done;
    logic [63:0] result;
    logic [5:0]  flags;
    logic        err_op;
    logic        busy;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;

    int vectors     = 0;
    int miscompares = 0;

    fd_multiciclo #(.DATA_W(64), .REG_ADDR_W(5), .MEM_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .OP(OP), .Ra(Ra), .Rb(Rb), .Rw(Rw), .OFFSET(OFFSET),
        .done(done), .result(result), .flags(flags), .err_op(err_op), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [4:0] addr, input logic [63:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Issue one command, scramble the inputs after acceptance, and count edges to done.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [4:0] rw, input logic [63:0] off,
                           input int exp_edges, input logic [63:0] exp_res, input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        OP = op; Ra = ra; Rb = rb; Rw = rw; OFFSET = off; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; OP = 3'd7; Ra = 5'd31; Rb = 5'd31; Rw = 5'd1; OFFSET = '1;
        n = 1;
        while (n < 8) begin
            @(negedge clk);
            if (done === 1'b1) break;
            @(posedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
        chk({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; OP = 3'd0; Ra = 5'd0; Rb = 5'd0; Rw = 5'd0;
        OFFSET = 64'd0; dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done",   64'(done),      64'd0);
        chk("rst_result", result,         64'd0);
        chk("rst_flags",  64'(flags),     64'd0);
        chk("rst_err",    64'(err_op),    64'd0);
        chk("rst_ready",  64'(cmd_ready), 64'd1);
        chk("rst_busy",   64'(busy),      64'd0);
        rst_n = 1'b1;

        run_cmd(3'd2, 5'd0, 5'd0, 5'd1, 64'd5, 3, 64'd5, "addi_r1");
        run_cmd(3'd2, 5'd0, 5'd0, 5'd2, 64'd7, 3, 64'd7, "addi_r2");
        run_cmd(3'd0, 5'd1, 5'd2, 5'd3, 64'd0, 3, 64'd12, "add_r3");
        chk("add_flags", 64'(flags), 64'(6'b100000));
        chk_reg(5'd3, 64'd12, "dbg_r3");

        run_cmd(3'd3, 5'd0, 5'd0, 5'd4, 64'd1, 3, 64'hFFFF_FFFF_FFFF_FFFF, "subi_r4");
        chk("subi_flags", 64'(flags), 64'(6'b100010));

        run_cmd(3'd2, 5'd0, 5'd0, 5'd5, 64'h7FFF_FFFF_FFFF_FFFF, 3, 64'h7FFF_FFFF_FFFF_FFFF, "addi_max");
        chk("addi_max_flags", 64'(flags), 64'(6'b100000));
        run_cmd(3'd2, 5'd5, 5'd0, 5'd5, 64'd1, 3, 64'h8000_0000_0000_0000, "addi_ovf");
        chk("ovf_flags", 64'(flags), 64'(6'b001010));

        run_cmd(3'd5, 5'd3, 5'd1, 5'd7, 64'd35, 4, 64'd40, "store_wrap");
        chk_reg(5'd7, 64'd0, "store_no_regwr");
        run_cmd(3'd4, 5'd0, 5'd0, 5'd6, 64'd8, 4, 64'd12, "load_r6");
        chk_reg(5'd6, 64'd12, "dbg_r6");

        run_cmd(3'd6, 5'd1, 5'd1, 5'd2, 64'd3, 3, 64'd0, "illegal");
        chk("illegal_err",   64'(err_op), 64'd1);
        chk("illegal_flags", 64'(flags),  64'(6'b100000));
        chk_reg(5'd2, 64'd7, "illegal_r2");

        run_cmd(3'd2, 5'd0, 5'd0, 5'd0, 64'd9, 3, 64'd9, "addi_r0");
        chk("addi_r0_err", 64'(err_op), 64'd0);
        chk_reg(5'd0, 64'd0, "dbg_r0");

        // Back-to-back: cmd_valid held high, each command accepted in the previous done cycle.
        @(negedge clk);
        OP = 3'd2; Ra = 5'd1; Rb = 5'd0; Rw = 5'd1; OFFSET = 64'd1; cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_busy", 64'(busy), 64'd1);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("b2b_done",  64'(done),      64'd1);
            chk("b2b_ready", 64'(cmd_ready), 64'd1);
            chk_reg(5'd1, 64'(6 + k), "b2b_r1");
        end
        cmd_valid = 1'b0;
        chk("b2b_result", result, 64'd9);

        // Reset during MEM of a STORE to mem[8]: the old word (12) must survive.
        @(negedge clk);
        OP = 3'd5; Ra = 5'd1; Rb = 5'd0; Rw = 5'd0; OFFSET = 64'd8; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mem_state_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 64'(cmd_ready), 64'd1);
        chk("rstmid_done",  64'(done),      64'd0);
        for (int i = 1; i < 8; i++) chk_reg(5'(i), 64'd0, "rstmid_reg");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_no_done", 64'(done),   64'd0);
        chk("rstmid_result",  result,      64'd0);
        chk("rstmid_flags",   64'(flags),  64'd0);
        rst_n = 1'b1;
        run_cmd(3'd4, 5'd0, 5'd0, 5'd6, 64'd8, 4, 64'd12, "load_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
